// File: rtl/mux_key_table.sv
// Runtime-programmable key/value table with a one-deep registered lookup stage.
// Lookups read the table as it stood before any same-edge write or clear.
module mux_key_table #(
  parameter  int NR_KEY   = 4,
  parameter  int KEY_LEN  = 2,
  parameter  int DATA_LEN = 2,
  localparam int IDX_LEN  = $clog2(NR_KEY)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                wr_en,
  input  logic [IDX_LEN-1:0]  wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic [DATA_LEN-1:0] default_out,
  input  logic                lk_valid,
  output logic                lk_ready,
  input  logic [KEY_LEN-1:0]  lk_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_data,
  output logic                out_hit,
  output logic [IDX_LEN-1:0]  out_idx
);

  // Handshake: a lookup transfers on an edge where lk_valid && lk_ready;
  // a result transfers on an edge where out_valid && out_ready.
  localparam logic [IDX_LEN:0] NR_KEY_W = (IDX_LEN+1)'(NR_KEY);

  logic [NR_KEY-1:0]   valid_q, valid_d;
  logic [KEY_LEN-1:0]  key_q  [NR_KEY];
  logic [KEY_LEN-1:0]  key_d  [NR_KEY];
  logic [DATA_LEN-1:0] data_q [NR_KEY];
  logic [DATA_LEN-1:0] data_d [NR_KEY];

  logic                out_valid_q, out_valid_d;
  logic [DATA_LEN-1:0] out_data_q, out_data_d;
  logic                out_hit_q, out_hit_d;
  logic [IDX_LEN-1:0]  out_idx_q, out_idx_d;

  logic                wr_in_range;
  logic                accept;
  logic                match_hit;
  logic [IDX_LEN-1:0]  match_idx;
  logic [DATA_LEN-1:0] match_data;

  assign wr_in_range = ({1'b0, wr_idx} < NR_KEY_W);
  assign lk_ready    = !out_valid_q || out_ready;
  assign accept      = lk_valid && lk_ready;

  // Scan from the top so the lowest matching index is the last to assign.
  always_comb begin
    match_hit  = 1'b0;
    match_idx  = '0;
    match_data = default_out;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (valid_q[i] && (key_q[i] == lk_key)) begin
        match_hit  = 1'b1;
        match_idx  = IDX_LEN'(i);
        match_data = data_q[i];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = '0;
    end else if (wr_en && wr_in_range) begin
      valid_d[wr_idx] = 1'b1;
      key_d[wr_idx]   = wr_key;
      data_d[wr_idx]  = wr_data;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_hit_d   = out_hit_q;
    out_idx_d   = out_idx_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = match_data;
      out_hit_d   = match_hit;
      out_idx_d   = match_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_hit_q   <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_hit_q   <= out_hit_d;
      out_idx_q   <= out_idx_d;
    end
    key_q  <= key_d;
    data_q <= data_d;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_hit   = out_hit_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_mux_key_table.sv
// Bench for mux_key_table: directed scenarios followed by random traffic,
// all checked against a table-level model and an expected-result queue.
module tb_mux_key_table;

  localparam int NR_KEY   = 4;
  localparam int KEY_LEN  = 2;
  localparam int DATA_LEN = 2;
  localparam int IDX_LEN  = $clog2(NR_KEY);
  localparam int RW       = 1 + IDX_LEN + DATA_LEN;

  logic                clk = 1'b0;
  logic                rst, clr, wr_en, lk_valid, out_ready;
  logic [IDX_LEN-1:0]  wr_idx;
  logic [KEY_LEN-1:0]  wr_key, lk_key;
  logic [DATA_LEN-1:0] wr_data, default_out;
  logic                lk_ready, out_valid, out_hit;
  logic [DATA_LEN-1:0] out_data;
  logic [IDX_LEN-1:0]  out_idx;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  // Model: table contents and queued results {hit, idx, data}.
  logic [NR_KEY-1:0]   m_valid;
  logic [KEY_LEN-1:0]  m_key  [NR_KEY];
  logic [DATA_LEN-1:0] m_data [NR_KEY];
  logic [RW-1:0]       exp_q[$];

  mux_key_table #(.NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_key(wr_key), .wr_data(wr_data), .default_out(default_out),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_key(lk_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_hit(out_hit), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] model_lookup(input logic [KEY_LEN-1:0] key,
                                                 input logic [DATA_LEN-1:0] dflt);
    for (int i = 0; i < NR_KEY; i++)
      if (m_valid[i] && m_key[i] == key) return {1'b1, IDX_LEN'(i), m_data[i]};
    return {1'b0, {IDX_LEN{1'b0}}, dflt};
  endfunction

  // One clock: check outputs, predict the edge, advance the model.
  task automatic tick();
    logic          acc;
    logic [RW-1:0] res, head;
    #1;
    if (checking) begin
      check("out_valid", out_valid, exp_q.size() != 0);
      check("lk_ready", lk_ready, (exp_q.size() == 0) || out_ready);
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        check("out_hit", out_hit, head[RW-1]);
        check("out_idx", out_idx, head[RW-2 -: IDX_LEN]);
        check("out_data", out_data, head[DATA_LEN-1:0]);
      end
    end
    acc = lk_valid && ((exp_q.size() == 0) || out_ready);
    res = model_lookup(lk_key, default_out);
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_valid = '0;
    end else begin
      if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(res);
      if (clr) m_valid = '0;
      else if (wr_en && int'(wr_idx) < NR_KEY) begin
        m_valid[wr_idx] = 1'b1;
        m_key[wr_idx]   = wr_key;
        m_data[wr_idx]  = wr_data;
      end
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; clr = 0; wr_en = 0; lk_valid = 0;
  endtask

  task automatic write(input int idx, input int key, input int data);
    idle();
    wr_en = 1; wr_idx = IDX_LEN'(idx); wr_key = KEY_LEN'(key); wr_data = DATA_LEN'(data);
    tick();
    wr_en = 0;
  endtask

  task automatic lookup(input int key);
    idle();
    lk_valid = 1; lk_key = KEY_LEN'(key);
    tick();
    lk_valid = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_hit"}, out_hit, 0);
    check({tag, "_idx"}, out_idx, 0);
  endtask

  initial begin
    idle();
    wr_idx = '0; wr_key = '0; wr_data = '0; lk_key = '0;
    default_out = 2'b11; out_ready = 1; m_valid = '0;
    rst = 1;
    tick(); tick();
    rst = 0;
    check_zero_outputs("reset");
    checking = 1'b1;

    // Empty-table lookup returns default one cycle later.
    lookup(1);
    check("first_miss_data", out_data, 2'b11);
    check("first_miss_hit", out_hit, 0);
    tick();

    // Load three entries, then four back-to-back lookups with no bubbles.
    write(0, 1, 2); write(1, 2, 1); write(3, 3, 3);
    lk_valid = 1;
    for (int k = 0; k < 4; k++) begin
      lk_key = KEY_LEN'((k + 1) % 4);
      tick();
    end
    lk_valid = 0;
    tick(); tick();

    // Duplicate key: lowest index wins.
    write(2, 2, 0); write(1, 2, 1);
    lookup(2);
    check("dup_idx", out_idx, 1);
    check("dup_data", out_data, 1);
    tick();

    // Same-edge write and lookup sees the old (cleared) table.
    idle(); clr = 1; tick(); clr = 0;
    wr_en = 1; wr_idx = 0; wr_key = 1; wr_data = 2;
    lk_valid = 1; lk_key = 1;
    tick();
    idle();
    check("rbw_hit", out_hit, 0);
    lookup(1);
    check("rbw_next_hit", out_hit, 1);
    tick();

    // Stall: result frozen while key changes and the matched entry is rewritten.
    lookup(1);
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      lk_valid = 1; lk_key = KEY_LEN'($urandom_range(0, 3));
      wr_en = 1; wr_idx = 0; wr_key = 1; wr_data = DATA_LEN'(k);
      tick();
    end
    idle();
    out_ready = 1;
    lk_valid = 1; lk_key = 1;
    tick();
    idle(); tick(); tick();

    // Clear beats a simultaneous write.
    idle(); clr = 1; wr_en = 1; wr_idx = 0; wr_key = 3; wr_data = 1;
    tick();
    idle();
    lookup(3);
    check("clr_wins_hit", out_hit, 0);
    tick();

    // Reset while a result is held.
    write(2, 0, 2);
    lookup(0);
    out_ready = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    check_zero_outputs("rst_held");
    out_ready = 1;
    lookup(0);
    check("rst_table_hit", out_hit, 0);
    tick();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 199) == 0);
      clr         = ($urandom_range(0, 29) == 0);
      wr_en       = ($urandom_range(0, 2) == 0);
      wr_idx      = IDX_LEN'($urandom_range(0, NR_KEY - 1));
      wr_key      = KEY_LEN'($urandom);
      wr_data     = DATA_LEN'($urandom);
      default_out = DATA_LEN'($urandom);
      lk_valid    = ($urandom_range(0, 2) != 0);
      lk_key      = KEY_LEN'($urandom);
      out_ready   = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle();
    out_ready = 1;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
